// File: rtl/float_to_int.sv
// Pipelined float32 -> int32 converter: unpack/classify, align, round/saturate.
// Define FLOAT_TO_INT_FLAGS_EN to add the {invalid, inexact} flags output.
module float_to_int #(
  parameter logic [31:0] NAN_RESULT = 32'h80000000,
  parameter logic [31:0] POS_SAT    = 32'h7fffffff,
  parameter logic [31:0] NEG_SAT    = 32'h80000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [31:0] a,
  input  logic [1:0]  roundMode,
  output logic        outValid,
  input  logic        outReady,
`ifdef FLOAT_TO_INT_FLAGS_EN
  output logic [1:0]  flags,
`endif
  output logic [31:0] result
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [1:0]  rm;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [1:0]  rm;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic        ovf;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } s2_t;

  logic              adv;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_d, vld_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic [31:0]       result_d, result_q;

  // Whole pipe moves together; any stall at the output freezes every stage.
  assign vld_pipe = {vld_q, inValid};
  assign outValid = vld_pipe[STAGES];
  assign adv      = !outValid || outReady;
  assign inReady  = adv;
  assign result   = result_q;

  always_comb begin
    vld_d = vld_q;
    if (adv) vld_d = vld_pipe[STAGES-1:0];
  end

  // S1: unpack and classify
  always_comb begin
    s1_d = s1_q;
    if (adv) begin
      s1_d.sign    = a[31];
      s1_d.exp     = a[30:23];
      s1_d.mant    = {|a[30:23], a[22:0]};
      s1_d.rm      = roundMode;
      s1_d.is_nan  = (&a[30:23]) && (|a[22:0]);
      s1_d.is_inf  = (&a[30:23]) && !(|a[22:0]);
      s1_d.is_zero = !(|a[30:0]);
    end
  end

  // S2: align to an integer magnitude plus guard/sticky
  logic [3:0]  lsh;
  logic [7:0]  rsh;
  logic [4:0]  rsh_c;
  logic [49:0] ext;

  always_comb begin
    s2_d  = s2_q;
    lsh   = 4'(s1_q.exp - 8'd150);
    rsh   = 8'd150 - s1_q.exp;
    // Clamping at 26 leaves mag=0, guard=0 and the whole mantissa in sticky.
    rsh_c = (rsh > 8'd26) ? 5'd26 : rsh[4:0];
    ext   = {s1_q.mant, 26'b0} >> rsh_c;
    if (adv) begin
      s2_d.sign    = s1_q.sign;
      s2_d.rm      = s1_q.rm;
      s2_d.is_nan  = s1_q.is_nan;
      s2_d.is_inf  = s1_q.is_inf;
      s2_d.is_zero = s1_q.is_zero;
      s2_d.mag     = '0;
      s2_d.guard   = 1'b0;
      s2_d.sticky  = 1'b0;
      s2_d.ovf     = 1'b0;
      // A shift of exactly 8 still fits in 32 bits, so -2^31 survives unsaturated.
      if (s1_q.exp > 8'd158) begin
        s2_d.ovf = 1'b1;
      end else if (s1_q.exp >= 8'd150) begin
        s2_d.mag = {8'b0, s1_q.mant} << lsh;
      end else begin
        s2_d.mag    = {8'b0, ext[49:26]};
        s2_d.guard  = ext[25];
        s2_d.sticky = |ext[24:0];
      end
    end
  end

  // S3: round, apply sign, saturate
  logic        inexact_c;
  logic        inc_c;
  logic        over_c;
  logic [32:0] magp_c;
  logic [31:0] res_c;

  always_comb begin
    inexact_c = s2_q.guard | s2_q.sticky;
    inc_c     = 1'b0;
    case (s2_q.rm)
      2'b00:   inc_c = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
      2'b01:   inc_c = 1'b0;
      2'b10:   inc_c = !s2_q.sign & inexact_c;
      default: inc_c = s2_q.sign & inexact_c;
    endcase
    magp_c = {1'b0, s2_q.mag} + 33'(inc_c);
    over_c = s2_q.ovf || (s2_q.sign ? (magp_c > 33'h080000000)
                                    : (magp_c > 33'h07fffffff));
    if (s2_q.is_nan)                    res_c = NAN_RESULT;
    else if (s2_q.is_inf || over_c)     res_c = s2_q.sign ? NEG_SAT : POS_SAT;
    else if (s2_q.is_zero)              res_c = '0;
    else if (s2_q.sign)                 res_c = 32'd0 - magp_c[31:0];
    else                                res_c = magp_c[31:0];
    result_d = adv ? res_c : result_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      result_q <= '0;
    end else begin
      vld_q    <= vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
    end
  end

`ifdef FLOAT_TO_INT_FLAGS_EN
  logic       invalid_c;
  logic [1:0] flags_d, flags_q;

  always_comb begin
    invalid_c = s2_q.is_nan || s2_q.is_inf || over_c;
    flags_d   = flags_q;
    if (adv) flags_d = {invalid_c, inexact_c && !invalid_c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule
